// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default widths, reset PC, NOP encoding and fetch FSM states.
package pipeline_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry instruction/PC holding register used while fetch is stalled.
module fetch_hold_buf
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  d_valid,
  input  logic [DATA_WIDTH-1:0] d_instr,
  input  logic [DATA_WIDTH-1:0] d_pc,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= d_valid;
      instr <= d_instr;
      pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with one-cycle memory latency, stall hold buffer and redirect.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  ValidF,
  output logic                  MisalignF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0] FetchCntF,
  output logic [DATA_WIDTH-1:0] BubbleCntF
`endif
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(NOP_INSTR);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] resp_pc_q;
  logic                  resp_valid_q;
  logic                  misalign_q;

  logic                  hb_load, hb_clear, hb_valid;
  logic [DATA_WIDTH-1:0] hb_instr, hb_pc;

  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_instr, sel_pc;

  assign imem_req  = !StallF || PCSrcE;
  assign imem_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    hb_load  = 1'b0;
    hb_clear = 1'b0;
    if (PCSrcE) begin
      state_d  = RUN;
      hb_clear = 1'b1;
    end else if (StallF) begin
      state_d = HOLD;
      // Capture only on entry; later stalled cycles must not see the bus.
      hb_load = (state_q != HOLD);
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      misalign_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= PCSrcE && (PCTargetE[1:0] != 2'b00);
      if (PCSrcE) begin
        pc_q         <= {PCTargetE[DATA_WIDTH-1:2], 2'b00};
        resp_valid_q <= 1'b0;
      end else if (!StallF) begin
        pc_q         <= pc_q + PC_STEP;
        resp_valid_q <= 1'b1;
        resp_pc_q    <= pc_q;
      end
    end
  end

  fetch_hold_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold_buf (
    .clk    (clk),
    .rst    (rst),
    .load   (hb_load),
    .clear  (hb_clear),
    .d_valid(resp_valid_q),
    .d_instr(imem_rdata),
    .d_pc   (resp_pc_q),
    .valid  (hb_valid),
    .instr  (hb_instr),
    .pc     (hb_pc)
  );

  always_comb begin
    sel_valid = resp_valid_q;
    sel_instr = imem_rdata;
    sel_pc    = resp_pc_q;
    if (state_q == HOLD) begin
      sel_valid = hb_valid;
      sel_instr = hb_instr;
      sel_pc    = hb_pc;
    end
  end

  assign ValidF    = sel_valid;
  assign InstrF    = sel_valid ? sel_instr : NOP;
  assign PCF       = sel_pc;
  assign PCPlus4F  = sel_pc + PC_STEP;
  assign MisalignF = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      FetchCntF  <= '0;
      BubbleCntF <= '0;
    end else if (ValidF) begin
      if (FetchCntF != '1) FetchCntF <= FetchCntF + CNT_ONE;
    end else begin
      if (BubbleCntF != '1) BubbleCntF <= BubbleCntF + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stall/redirect/reset
// traffic checked against an in-order program-stream model.
module tb_fetch_unit;
  import pipeline_pkg::*;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst, StallF, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] mask;

  logic        imem_req, ValidF, MisalignF;
  logic [31:0] imem_addr, imem_rdata, InstrF, PCF, PCPlus4F;
  logic        imem_req_w, ValidF_w, MisalignF_w;
  logic [31:0] imem_addr_w, imem_rdata_w, InstrF_w, PCF_w, PCPlus4F_w;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCntF, BubbleCntF, FetchCntF_w, BubbleCntF_w;
`endif

  int unsigned n_pass, n_total;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .MisalignF(MisalignF)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCntF(FetchCntF), .BubbleCntF(BubbleCntF)
`endif
  );

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .InstrF(InstrF_w), .PCF(PCF_w), .PCPlus4F(PCPlus4F_w), .ValidF(ValidF_w), .MisalignF(MisalignF_w)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCntF(FetchCntF_w), .BubbleCntF(BubbleCntF_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data = addr ^ mask one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? (imem_addr   ^ mask) : $urandom;
    imem_rdata_w <= imem_req_w ? (imem_addr_w ^ mask) : $urandom;
  end

  task automatic tick(input logic r, input logic s, input logic p, input logic [31:0] t);
    rst = r; StallF = s; PCSrcE = p; PCTargetE = t;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    n_total++; if (ValidF !== 1'b0) $display("FAIL reset_valid: got %0b want 0", ValidF); else n_pass++;
    n_total++; if (InstrF !== NOP) $display("FAIL reset_instr: got %h want %h", InstrF, NOP); else n_pass++;
    n_total++; if (PCF !== 32'h0) $display("FAIL reset_pc: got %h want 00000000", PCF); else n_pass++;
    n_total++; if (MisalignF !== 1'b0) $display("FAIL reset_mis: got %0b want 0", MisalignF); else n_pass++;
    n_total++; if (PCF_w !== WRAP_PC) $display("FAIL reset_pc_wrap: got %h want %h", PCF_w, WRAP_PC); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL boot_addr: got %h want 00000000", imem_addr); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
    n_total++; if (FetchCntF !== 32'h0 || BubbleCntF !== 32'h0)
      $display("FAIL reset_cnt: got %h/%h want 0/0", FetchCntF, BubbleCntF); else n_pass++;
`endif
  endtask

  task automatic test_sequential_and_wrap();
    logic [31:0] e, ew;
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      e  = 32'(i * 4);
      ew = WRAP_PC + e;
      n_total++; if (ValidF !== 1'b1 || PCF !== e || InstrF !== e)
        $display("FAIL seq_%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", i, ValidF, PCF, InstrF, e, e); else n_pass++;
      n_total++; if (PCPlus4F !== e + 32'd4) $display("FAIL seq_pc4_%0d: got %h want %h", i, PCPlus4F, e + 32'd4); else n_pass++;
      n_total++; if (ValidF_w !== 1'b1 || PCF_w !== ew)
        $display("FAIL wrap_pc_%0d: got v=%0b pc=%h want v=1 pc=%h", i, ValidF_w, PCF_w, ew); else n_pass++;
      n_total++; if (PCPlus4F_w !== ew + 32'd4) $display("FAIL wrap_pc4_%0d: got %h want %h", i, PCPlus4F_w, ew + 32'd4); else n_pass++;
      if (i < 2) tick(0, 0, 0, 0);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0);
      n_total++; if (ValidF !== 1'b1 || PCF !== 32'h8 || InstrF !== 32'h8)
        $display("FAIL stall_hold_%0d: got v=%0b pc=%h instr=%h want v=1 pc=00000008 instr=00000008", k, ValidF, PCF, InstrF); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL stall_req_%0d: got %0b want 0", k, imem_req); else n_pass++;
    end
    tick(0, 0, 0, 0);
    n_total++; if (ValidF !== 1'b1 || PCF !== 32'hC || InstrF !== 32'hC)
      $display("FAIL stall_release: got v=%0b pc=%h instr=%h want v=1 pc=0000000c", ValidF, PCF, InstrF); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (PCF !== 32'h10) $display("FAIL stall_after: got %h want 00000010", PCF); else n_pass++;
  endtask

  task automatic test_redirect();
    tick(0, 0, 1, 32'h100);
    n_total++; if (ValidF !== 1'b0 || InstrF !== NOP)
      $display("FAIL redir_bubble: got v=%0b instr=%h want v=0 instr=%h", ValidF, InstrF, NOP); else n_pass++;
    n_total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr: got %h want 00000100", imem_addr); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (ValidF !== 1'b1 || PCF !== 32'h100 || InstrF !== 32'h100)
      $display("FAIL redir_target: got v=%0b pc=%h instr=%h want v=1 pc=00000100", ValidF, PCF, InstrF); else n_pass++;
    tick(0, 1, 1, 32'h100);
    n_total++; if (ValidF !== 1'b0) $display("FAIL redir_stall_bubble: got %0b want 0", ValidF); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (ValidF !== 1'b1 || PCF !== 32'h100)
      $display("FAIL redir_stall_target: got v=%0b pc=%h want v=1 pc=00000100", ValidF, PCF); else n_pass++;
  endtask

  task automatic test_misalign();
    tick(0, 0, 1, 32'h102);
    n_total++; if (MisalignF !== 1'b1 || ValidF !== 1'b0)
      $display("FAIL mis_pulse: got mis=%0b v=%0b want mis=1 v=0", MisalignF, ValidF); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (MisalignF !== 1'b0 || ValidF !== 1'b1 || PCF !== 32'h100)
      $display("FAIL mis_target: got mis=%0b v=%0b pc=%h want mis=0 v=1 pc=00000100", MisalignF, ValidF, PCF); else n_pass++;
    tick(0, 0, 0, 0);
    n_total++; if (PCF !== 32'h104) $display("FAIL mis_next: got %h want 00000104", PCF); else n_pass++;
  endtask

  task automatic test_reset_in_hold();
    tick(0, 1, 0, 0);
    n_total++; if (PCF !== 32'h104 || ValidF !== 1'b1)
      $display("FAIL rsthold_pre: got v=%0b pc=%h want v=1 pc=00000104", ValidF, PCF); else n_pass++;
    tick(1, 1, 1, 32'h203);
    n_total++; if (ValidF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0 || MisalignF !== 1'b0)
      $display("FAIL rsthold_boot: got v=%0b instr=%h pc=%h mis=%0b want v=0 instr=%h pc=0 mis=0", ValidF, InstrF, PCF, MisalignF, NOP); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
    n_total++; if (FetchCntF !== 32'h0 || BubbleCntF !== 32'h0)
      $display("FAIL rsthold_cnt: got %h/%h want 0/0", FetchCntF, BubbleCntF); else n_pass++;
`endif
    tick(0, 0, 0, 0);
    n_total++; if (ValidF !== 1'b1 || PCF !== 32'h0)
      $display("FAIL rsthold_first: got v=%0b pc=%h want v=1 pc=0", ValidF, PCF); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
    n_total++; if (FetchCntF !== 32'h0 || BubbleCntF !== 32'h1)
      $display("FAIL rsthold_cnt_boot: got %h/%h want 0/1", FetchCntF, BubbleCntF); else n_pass++;
`endif
  endtask

  // Model: decode consumes the fetch output whenever it is valid and neither stalled nor flushed;
  // consumed PCs must follow RESET_PC, +4, ... restarting at the aligned target after a redirect.
  task automatic test_random();
    logic        r, s, p, prev_rst, prev_redir, prev_mis, prev_hold, prev_valid;
    logic [31:0] t, exp_next, prev_pc, prev_instr;
    int unsigned consumed;
    mask = 32'h5A5A_0000;
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    prev_rst = 1'b1; prev_redir = 1'b0; prev_mis = 1'b0; prev_hold = 1'b0;
    prev_valid = 1'b0; prev_pc = '0; prev_instr = '0;
    exp_next = 32'h0; consumed = 0;
    for (int c = 0; c < 3000; c++) begin
      if (prev_rst) begin
        n_total++; if (ValidF !== 1'b0 || PCF !== 32'h0 || InstrF !== NOP || MisalignF !== 1'b0)
          $display("FAIL rnd_rst c=%0d: got v=%0b pc=%h instr=%h mis=%0b", c, ValidF, PCF, InstrF, MisalignF); else n_pass++;
      end else begin
        n_total++; if (MisalignF !== (prev_redir & prev_mis))
          $display("FAIL rnd_mis c=%0d: got %0b want %0b", c, MisalignF, prev_redir & prev_mis); else n_pass++;
        if (prev_redir) begin
          n_total++; if (ValidF !== 1'b0) $display("FAIL rnd_flush c=%0d: got v=%0b want 0", c, ValidF); else n_pass++;
        end else if (prev_hold) begin
          n_total++; if (ValidF !== prev_valid || (prev_valid && (PCF !== prev_pc || InstrF !== prev_instr)))
            $display("FAIL rnd_hold c=%0d: got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h",
                     c, ValidF, PCF, InstrF, prev_valid, prev_pc, prev_instr); else n_pass++;
        end
      end
      if (ValidF === 1'b1) begin
        n_total++; if (InstrF !== (PCF ^ mask) || PCPlus4F !== PCF + 32'd4)
          $display("FAIL rnd_data c=%0d: got instr=%h pc4=%h want instr=%h pc4=%h", c, InstrF, PCPlus4F, PCF ^ mask, PCF + 32'd4); else n_pass++;
      end else begin
        n_total++; if (InstrF !== NOP) $display("FAIL rnd_nop c=%0d: got %h want %h", c, InstrF, NOP); else n_pass++;
      end
      r = ($urandom_range(99) < 1);
      s = ($urandom_range(99) < 25);
      p = ($urandom_range(99) < 6);
      t = ($urandom_range(1) == 1) ? $urandom : 32'($urandom_range(1023));
      if (r) exp_next = 32'h0;
      else if (p) exp_next = {t[31:2], 2'b00};
      else if (!s && ValidF === 1'b1) begin
        consumed++;
        n_total++; if (PCF !== exp_next) $display("FAIL rnd_order c=%0d: got pc=%h want %h", c, PCF, exp_next); else n_pass++;
        exp_next = exp_next + 32'd4;
      end
      prev_rst = r; prev_redir = p; prev_mis = (t[1:0] != 2'b00);
      prev_hold = s && !p; prev_valid = ValidF; prev_pc = PCF; prev_instr = InstrF;
      tick(r, s, p, t);
    end
    n_total++; if (consumed < 200) $display("FAIL rnd_progress: got %0d consumed want >= 200", consumed); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; mask = '0;
    rst = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    test_reset();
    test_sequential_and_wrap();
    test_stall();
    test_redirect();
    test_misalign();
    test_reset_in_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, 32, instruction and address width.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 StallF  input  1  hazard-unit stall; hold fetch state.
REQ-006 PCSrcE  input  1  redirect request from execute (taken branch/jump).
REQ-007 PCTargetE  input  DATA_WIDTH  redirect target address.
REQ-008 imem_req  output  1  instruction-memory read strobe.
REQ-009 imem_addr  output  DATA_WIDTH  read address; data returns exactly one cycle later.
REQ-010 imem_rdata  input  DATA_WIDTH  read data for the previous cycle's request.
REQ-011 InstrF  output  DATA_WIDTH  instruction to decode pipeline register input.
REQ-012 PCF  output  DATA_WIDTH  address of InstrF.
REQ-013 PCPlus4F  output  DATA_WIDTH  PCF + 4.
REQ-014 ValidF  output  1  InstrF/PCF hold a live instruction; 0 = bubble.
REQ-015 MisalignF  output  1  one-cycle pulse: redirect target had [1:0] != 0.

Function
REQ-016 Fetch PC register (pc_q) SHALL drive imem_addr combinationally; imem_req = !StallF && state != HOLD-without-release, i.e. imem_req = !StallF || PCSrcE.
REQ-017 States: BOOT, RUN, HOLD; BOOT entered on reset, lasts exactly one cycle, ValidF=0, then RUN.
REQ-018 Response tracking: resp_valid_q/resp_pc_q register set when imem_req issued; InstrF = imem_rdata, PCF = resp_pc_q in RUN; latency request-to-InstrF = 1 cycle.
REQ-019 Not stalled, no redirect: pc_q <= pc_q + 4, modulo 2^DATA_WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-020 RUN -> HOLD when StallF=1 and PCSrcE=0: capture imem_rdata, resp_pc_q into hold buffer same cycle; pc_q, resp state frozen; no request issued.
REQ-021 In HOLD: InstrF/PCF/ValidF driven from hold buffer, stable every stalled cycle regardless of imem_rdata.
REQ-022 HOLD -> RUN when StallF=0: hold buffer presented that cycle, request for pc_q issued same cycle, so following cycle shows pc_q's instruction; no instruction lost or duplicated.
REQ-023 Redirect (PCSrcE=1) SHALL override stall in any state: pc_q <= {PCTargetE[DW-1:2],2'b00}, request for target issued next cycle, in-flight response and hold buffer invalidated, ValidF=0 the cycle after PCSrcE, state -> RUN.
REQ-024 PCSrcE with PCTargetE[1:0] != 0: MisalignF=1 the cycle after, target aligned per REQ-023; otherwise MisalignF=0.
REQ-025 PCPlus4F = PCF + 4 with wrap, valid whenever ValidF=1; don't-care when ValidF=0.
REQ-026 ValidF=0 cycles SHALL drive InstrF = 32'h0000_0013 (NOP).

Reset
REQ-027 rst=1 at any edge, including mid-stall or mid-redirect: pc_q=RESET_PC, state=BOOT, resp_valid_q=0, hold buffer cleared, ValidF=0, MisalignF=0, InstrF=NOP, PCF=RESET_PC; rst overrides StallF and PCSrcE.
REQ-028 First request (address RESET_PC) issued in the BOOT cycle; first ValidF=1 the following cycle.

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: adds outputs FetchCntF and BubbleCntF (DATA_WIDTH each), count cycles with ValidF=1 / ValidF=0 outside reset, saturate at all-ones, cleared by rst.
REQ-030 FETCH_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package pipeline_pkg SHALL hold DATA_WIDTH default, RESET_PC default, NOP encoding 32'h0000_0013, fetch_state_t enum {BOOT, RUN, HOLD}.
REQ-032 One sub-module fetch_hold_buf: single-entry instruction/PC holding register with load, clear, valid.

Verification
REQ-033 Reset release, no stall, memory returning addr as data -> cycles after BOOT: PCF 0x0,0x4,0x8 with ValidF=1, InstrF matches.
REQ-034 StallF high 3 cycles while PCF=0x8 -> InstrF/PCF hold 0x8 for all 3 cycles plus release cycle, next PCF=0xC, no gap/duplicate.
REQ-035 PCSrcE=1, PCTargetE=0x100 at PCF=0x10 -> next cycle ValidF=0, following PCF=0x100 ValidF=1; PCSrcE with StallF=1 same result.
REQ-036 PCTargetE=0x102 -> MisalignF pulse 1 cycle, next valid PCF=0x100.
REQ-037 RESET_PC=0xFFFF_FFF8 -> PCF sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; PCPlus4F at 0xFFFF_FFFC = 0x0.
REQ-038 rst asserted during HOLD -> next cycle ValidF=0, InstrF=NOP; BOOT then PCF=RESET_PC; with FETCH_PERF_CNT_EN counters read 0 after reset.
